alu_seq: RTL

- Registered, parametrised ALU and the successor to the 8-bit combinational datapath ALU.
- Operand width is generic. Multi-bit shifts run iteratively, one bit per cycle.
- Adds SUB, a variable-distance arithmetic right shift, a valid/ready input handshake and a registered status-flag set (carry, zero, negative, overflow).
- Sits between the register file and the write-back stage of the CPU datapath.

---
 rtl/alu_seq_if.sv | 34 +++
 rtl/alu_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// Operation request / result bundle for alu_seq.
// With ALU_SEQ_ACC_EN defined the request also carries acc_sel.
interface alu_seq_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [2:0]       sel;
`ifdef ALU_SEQ_ACC_EN
    logic             acc_sel;
`endif
    logic [WIDTH-1:0] out;
    logic             co;
    logic             zf;
    logic             nf;
    logic             vf;
    logic             out_valid;

    modport master (
        output in_valid, op1, op2, sel,
`ifdef ALU_SEQ_ACC_EN
        output acc_sel,
`endif
        input  in_ready, out, co, zf, nf, vf, out_valid
    );

    modport slave (
        input  in_valid, op1, op2, sel,
`ifdef ALU_SEQ_ACC_EN
        input  acc_sel,
`endif
        output in_ready, out, co, zf, nf, vf, out_valid
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with iterative one-bit-per-cycle shifts and registered C/Z/N/V flags.
// Optional ALU_SEQ_ACC_EN: acc_sel substitutes the last result for op1.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_ASHL = 3'b001,
        OP_XNOR = 3'b010,
        OP_DIV2 = 3'b011,
        OP_SUB  = 3'b100,
        OP_PASS = 3'b101,
        OP_NEG  = 3'b110,
        OP_SRA  = 3'b111
    } op_e;

    typedef enum logic {IDLE, SHIFT} state_e;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        op_e              op;
    } req_t;

    typedef struct packed {
        logic [WIDTH-1:0] r;
        logic             co;
        logic             vf;
    } rsp_t;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] wrk_q, wrk_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             is_sra_q, is_sra_d;
    logic             vacc_q, vacc_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             co_q, co_d, zf_q, zf_d, nf_q, nf_d, vf_q, vf_d;
    logic             vld_q, vld_d;

    req_t             req;
    logic             accept;
    logic             is_shift;
    logic [SHW-1:0]   n;
    logic [WIDTH:0]   sum, dif;
    rsp_t             sng, rsp;
    logic [WIDTH-1:0] sh_nxt;
    logic             sh_bit, sh_vf;
    logic             done;

    assign req.b  = bus.op2;
    assign req.op = op_e'(bus.sel);
`ifdef ALU_SEQ_ACC_EN
    // The accumulator is the registered result itself.
    assign req.a  = bus.acc_sel ? out_q : bus.op1;
`else
    assign req.a  = bus.op1;
`endif

    assign accept   = bus.in_valid && (state_q == IDLE);
    assign is_shift = (req.op == OP_ASHL) || (req.op == OP_SRA);
    assign n        = (32'(req.b) >= 32'(WIDTH)) ? SHW'(WIDTH) : SHW'(req.b);
    assign sum      = {1'b0, req.a} + {1'b0, req.b};
    assign dif      = {1'b0, req.a} - {1'b0, req.b};

    always_comb begin
        sng.r  = req.a;
        sng.co = 1'b0;
        sng.vf = 1'b0;
        case (req.op)
            OP_ADD: begin
                sng.r  = sum[WIDTH-1:0];
                sng.co = sum[WIDTH];
                sng.vf = (req.a[WIDTH-1] == req.b[WIDTH-1]) && (sum[WIDTH-1] != req.a[WIDTH-1]);
            end
            OP_SUB: begin
                // co is "no borrow", i.e. op1 >= op2 unsigned.
                sng.r  = dif[WIDTH-1:0];
                sng.co = ~dif[WIDTH];
                sng.vf = (req.a[WIDTH-1] != req.b[WIDTH-1]) && (dif[WIDTH-1] != req.a[WIDTH-1]);
            end
            OP_XNOR: sng.r = ~(req.a ^ req.b);
            OP_DIV2: begin
                sng.r  = {req.a[WIDTH-1], req.a[WIDTH-1:1]};
                sng.co = req.a[0];
            end
            OP_NEG:  sng.r = ~req.a + 1'b1;
            default: ;
        endcase
    end

    // One shift step on the working register; vf records any sign change.
    always_comb begin
        if (is_sra_q) begin
            sh_nxt = {wrk_q[WIDTH-1], wrk_q[WIDTH-1:1]};
            sh_bit = wrk_q[0];
            sh_vf  = 1'b0;
        end else begin
            sh_nxt = {wrk_q[WIDTH-2:0], 1'b0};
            sh_bit = wrk_q[WIDTH-1];
            sh_vf  = wrk_q[WIDTH-1] ^ wrk_q[WIDTH-2];
        end
    end

    always_comb begin
        state_d  = state_q;
        wrk_d    = wrk_q;
        cnt_d    = cnt_q;
        is_sra_d = is_sra_q;
        vacc_d   = vacc_q;
        done     = 1'b0;
        rsp      = sng;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_shift && (n != '0)) begin
                        state_d  = SHIFT;
                        wrk_d    = req.a;
                        cnt_d    = n;
                        is_sra_d = (req.op == OP_SRA);
                        vacc_d   = 1'b0;
                    end else begin
                        done = 1'b1;
                    end
                end
            end
            SHIFT: begin
                wrk_d  = sh_nxt;
                cnt_d  = cnt_q - SHW'(1);
                vacc_d = vacc_q | sh_vf;
                if (cnt_q == SHW'(1)) begin
                    state_d = IDLE;
                    done    = 1'b1;
                    rsp.r   = sh_nxt;
                    rsp.co  = sh_bit;
                    rsp.vf  = vacc_q | sh_vf;
                end
            end
            default: state_d = IDLE;
        endcase

        out_d = done ? rsp.r : out_q;
        co_d  = done ? rsp.co : co_q;
        vf_d  = done ? rsp.vf : vf_q;
        zf_d  = done ? (rsp.r == '0) : zf_q;
        nf_d  = done ? rsp.r[WIDTH-1] : nf_q;
        vld_d = done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wrk_q    <= '0;
            cnt_q    <= '0;
            is_sra_q <= 1'b0;
            vacc_q   <= 1'b0;
            out_q    <= '0;
            co_q     <= 1'b0;
            zf_q     <= 1'b1;
            nf_q     <= 1'b0;
            vf_q     <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wrk_q    <= wrk_d;
            cnt_q    <= cnt_d;
            is_sra_q <= is_sra_d;
            vacc_q   <= vacc_d;
            out_q    <= out_d;
            co_q     <= co_d;
            zf_q     <= zf_d;
            nf_q     <= nf_d;
            vf_q     <= vf_d;
            vld_q    <= vld_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out       = out_q;
    assign bus.co        = co_q;
    assign bus.zf        = zf_q;
    assign bus.nf        = nf_q;
    assign bus.vf        = vf_q;
    assign bus.out_valid = vld_q;
endmodule
